// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Purpose : Shared constants and types for the hazard/scoreboard unit:
//           forwarding select encodings and MDU scoreboard state encoding.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  // Forwarding mux selects for the E-stage ALU operands
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_W       = 2'b01;
  localparam logic [1:0] FWD_M       = 2'b10;

  // MDU scoreboard states
  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_scoreboard.sv
// ============================================================================
// Module  : mdu_scoreboard
// Purpose : Tracks one in-flight multi-cycle multiply/divide op. Captures the
//           destination on issue, counts down MDU_LATENCY cycles and raises a
//           one-cycle write enable for the register file's second write port.
// Ports   : clk, rst     - clock, async active-high reset
//           start        - MDU op issues from Execute this cycle
//           wr_reg       - destination register of the issuing op
//           busy         - op in flight
//           wb_en        - result write enable (one cycle)
//           wb_reg       - destination register of the op in flight
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MDU_LATENCY    = 4,
  parameter int CNT_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [REG_ADDR_WIDTH-1:0] wr_reg,
  output logic                      busy,
  output logic                      wb_en,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg
);

  localparam logic [CNT_WIDTH-1:0] C_LATENCY = CNT_WIDTH'(MDU_LATENCY);
  localparam logic [CNT_WIDTH-1:0] C_ONE     = CNT_WIDTH'(1);

  mdu_state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]      r_cnt,   w_cnt_nxt;
  logic [REG_ADDR_WIDTH-1:0] r_dest,  w_dest_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
      r_dest  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dest  <= w_dest_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dest_nxt  = r_dest;
    busy        = 1'b0;
    wb_en       = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        if (start) begin
          w_state_nxt = MDU_BUSY;
          w_cnt_nxt   = C_LATENCY;
          w_dest_nxt  = wr_reg;
        end
      end
      MDU_BUSY: begin
        // A second start while busy is illegal (structurally stalled) and ignored.
        busy      = 1'b1;
        w_cnt_nxt = r_cnt - C_ONE;
        if (r_cnt == C_ONE) begin
          wb_en       = 1'b1;
          w_state_nxt = MDU_IDLE;
        end
      end
      default: w_state_nxt = MDU_IDLE;
    endcase
  end

  assign wb_reg = r_dest;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
// ============================================================================
// Module  : hazard_scoreboard_unit
// Purpose : Hazard unit for the 5-stage MIPS core. Produces E/D forwarding
//           selects, load-use / branch / MDU stall and flush controls, tracks
//           one in-flight MDU op and counts stalled cycles (saturating).
// Ports   : clk, rst                         - clock, async active-high reset
//           BranchD, MduOpD, RegWriteD,
//           RsD, RtD, WriteRegD              - Decode stage info
//           RsE, RtE, WriteRegE, RegWriteE,
//           MemtoRegE, MduStartE             - Execute stage info
//           WriteRegM, RegWriteM, MemtoRegM  - Memory stage info
//           WriteRegW, RegWriteW             - Writeback stage info
//           ForwardAE/BE, ForwardAD/BD       - forwarding selects
//           StallF, StallD, FlushE           - pipeline control
//           MduWbEn, MduWbReg, MduBusy       - MDU scoreboard status
//           StallCount                       - saturating StallD cycle count
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FWD_SEL_WIDTH   = 2,
  parameter int MDU_LATENCY     = 4,
  parameter int CNT_WIDTH       = 3,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       BranchD,
  input  logic                       MduOpD,
  input  logic                       RegWriteD,
  input  logic [REG_ADDR_WIDTH-1:0]  RsD,
  input  logic [REG_ADDR_WIDTH-1:0]  RtD,
  input  logic [REG_ADDR_WIDTH-1:0]  WriteRegD,
  input  logic [REG_ADDR_WIDTH-1:0]  RsE,
  input  logic [REG_ADDR_WIDTH-1:0]  RtE,
  input  logic [REG_ADDR_WIDTH-1:0]  WriteRegE,
  input  logic                       RegWriteE,
  input  logic                       MemtoRegE,
  input  logic                       MduStartE,
  input  logic [REG_ADDR_WIDTH-1:0]  WriteRegM,
  input  logic                       RegWriteM,
  input  logic                       MemtoRegM,
  input  logic [REG_ADDR_WIDTH-1:0]  WriteRegW,
  input  logic                       RegWriteW,
  output logic [FWD_SEL_WIDTH-1:0]   ForwardAE,
  output logic [FWD_SEL_WIDTH-1:0]   ForwardBE,
  output logic                       ForwardAD,
  output logic                       ForwardBD,
  output logic                       StallF,
  output logic                       StallD,
  output logic                       FlushE,
  output logic                       MduWbEn,
  output logic [REG_ADDR_WIDTH-1:0]  MduWbReg,
  output logic                       MduBusy,
  output logic [STALL_CNT_WIDTH-1:0] StallCount
);

  logic w_lwstall;
  logic w_branchstall;
  logic w_mdustall;
  logic w_stall;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  // --------------------------------------------------------------------------
  // E-stage forwarding: the M stage holds the younger result, so it wins.
  // --------------------------------------------------------------------------
  always_comb begin
    ForwardAE = FWD_SEL_WIDTH'(FWD_REGFILE);
    if (RsE != '0 && RsE == WriteRegM && RegWriteM)
      ForwardAE = FWD_SEL_WIDTH'(FWD_M);
    else if (RsE != '0 && RsE == WriteRegW && RegWriteW)
      ForwardAE = FWD_SEL_WIDTH'(FWD_W);

    ForwardBE = FWD_SEL_WIDTH'(FWD_REGFILE);
    if (RtE != '0 && RtE == WriteRegM && RegWriteM)
      ForwardBE = FWD_SEL_WIDTH'(FWD_M);
    else if (RtE != '0 && RtE == WriteRegW && RegWriteW)
      ForwardBE = FWD_SEL_WIDTH'(FWD_W);
  end

  assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

  // --------------------------------------------------------------------------
  // Stall sources
  // --------------------------------------------------------------------------
  assign w_lwstall = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));

  // Branch compares in D: an ALU result still in E, or a load still in M,
  // cannot be forwarded in time.
  assign w_branchstall = BranchD &&
      ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
       (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  // MDU hazards: RAW/WAW against the op in flight, RAW/WAW against the op
  // issuing this cycle (not yet captured), and the single-MDU structural limit.
  assign w_mdustall =
      (MduBusy && ((((RsD == MduWbReg) || (RtD == MduWbReg)) && (MduWbReg != '0)) ||
                   (RegWriteD && (WriteRegD == MduWbReg)))) ||
      (MduStartE && (WriteRegE != '0) &&
       ((WriteRegE == RsD) || (WriteRegE == RtD) || (RegWriteD && (WriteRegD == WriteRegE)))) ||
      (MduOpD && (MduBusy || MduStartE));

  assign w_stall = w_lwstall || w_branchstall || w_mdustall;
  assign StallF  = w_stall;
  assign StallD  = w_stall;
  assign FlushE  = w_stall;

  // --------------------------------------------------------------------------
  // MDU scoreboard
  // --------------------------------------------------------------------------
  mdu_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .MDU_LATENCY    (MDU_LATENCY),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_mdu_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .start  (MduStartE),
    .wr_reg (WriteRegE),
    .busy   (MduBusy),
    .wb_en  (MduWbEn),
    .wb_reg (MduWbReg)
  );

  // --------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign StallCount = r_stall_cnt;

endmodule

`default_nettype wire
